// File: rtl/ov_sccb_seq_if.sv
// ROM fetch port and SCCB master request/acknowledge bus for ov_sccb_seq.
// sccb_rd (read select) exists only when OV_SCCB_SEQ_VERIFY_EN is defined.
interface ov_sccb_seq_if #(
   parameter int ADDR_W = 6
);
   logic [ADDR_W-1:0] rom_addr;
   logic [15:0]       rom_data;
   logic [7:0]        sccb_subaddr;
   logic [7:0]        sccb_w_data;
   logic              sccb_tr_start;
   logic              sccb_tr_end;
   logic [7:0]        sccb_r_data;
`ifdef OV_SCCB_SEQ_VERIFY_EN
   logic              sccb_rd;

   modport master (
      output rom_addr, sccb_subaddr, sccb_w_data, sccb_tr_start, sccb_rd,
      input  rom_data, sccb_tr_end, sccb_r_data
   );
   modport slave (
      input  rom_addr, sccb_subaddr, sccb_w_data, sccb_tr_start, sccb_rd,
      output rom_data, sccb_tr_end, sccb_r_data
   );
`else
   modport master (
      output rom_addr, sccb_subaddr, sccb_w_data, sccb_tr_start,
      input  rom_data, sccb_tr_end, sccb_r_data
   );
   modport slave (
      input  rom_addr, sccb_subaddr, sccb_w_data, sccb_tr_start,
      output rom_data, sccb_tr_end, sccb_r_data
   );
`endif
endinterface

// File: rtl/ov_sccb_seq.sv
// ov_sccb_seq: walks a registered-ROM table of SCCB writes / delays / end marker; OV_SCCB_SEQ_VERIFY_EN adds readback compare.
// Write entry reaches tr_start 3 cycles after FETCH; every transfer waits on the full 4-phase tr_start/tr_end handshake.
module ov_sccb_seq #(
   parameter int         NUM_CMDS     = 64,
   parameter int         ADDR_W       = 6,
   parameter int         DELAY_CYCLES = 65536,
   parameter logic [7:0] DELAY_TAG    = 8'hF0,
   parameter logic [7:0] END_TAG      = 8'hFF,
   parameter bit         AUTO_START   = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   ov_sccb_seq_if.master    bus,
   output logic             busy,
   output logic             done,
   output logic             error
);
   localparam int                CNT_W    = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  DLY_LOAD = CNT_W'(DELAY_CYCLES - 1);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_CMDS - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_ISSUE,
      S_WAIT_ACK,
      S_WAIT_REL,
      S_DELAY,
`ifdef OV_SCCB_SEQ_VERIFY_EN
      S_VERIFY_ACK,
      S_VERIFY_REL,
`endif
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [7:0]        sub_q, sub_d;
   logic [7:0]        wdat_q, wdat_d;
   logic              tr_q, tr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              first_q, first_d;
   logic              adv;
   logic              go;
   logic [7:0]        rom_sub;
`ifdef OV_SCCB_SEQ_VERIFY_EN
   localparam logic [7:0] COM7 = 8'h12;
   logic              rd_q, rd_d;
   logic              err_q, err_d;
`else
   logic              unused_rdata;
   assign unused_rdata = ^bus.sccb_r_data;
`endif

   // first_q is set only by reset, so auto-start fires exactly once per reset release
   assign go      = start || (AUTO_START && first_q);
   assign rom_sub = bus.rom_data[15:8];

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      sub_d   = sub_q;
      wdat_d  = wdat_q;
      tr_d    = tr_q;
      busy_d  = busy_q;
      done_d  = done_q;
      first_d = 1'b0;
      adv     = 1'b0;
`ifdef OV_SCCB_SEQ_VERIFY_EN
      rd_d    = rd_q;
      err_d   = err_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (go) begin
               state_d = S_FETCH;
               idx_d   = '0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
`ifdef OV_SCCB_SEQ_VERIFY_EN
               err_d   = 1'b0;
`endif
            end
         end
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            if (rom_sub == END_TAG) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else if (rom_sub == DELAY_TAG) begin
               state_d = S_DELAY;
               cnt_d   = DLY_LOAD;
            end else begin
               state_d = S_ISSUE;
               sub_d   = rom_sub;
               wdat_d  = bus.rom_data[7:0];
            end
         end
         S_ISSUE: begin
            tr_d    = 1'b1;
            state_d = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (bus.sccb_tr_end) begin
               tr_d    = 1'b0;
               state_d = S_WAIT_REL;
            end
         end
         S_WAIT_REL: begin
            if (!bus.sccb_tr_end) begin
`ifdef OV_SCCB_SEQ_VERIFY_EN
               tr_d    = 1'b1;
               rd_d    = 1'b1;
               state_d = S_VERIFY_ACK;
`else
               adv     = 1'b1;
`endif
            end
         end
`ifdef OV_SCCB_SEQ_VERIFY_EN
         S_VERIFY_ACK: begin
            if (bus.sccb_tr_end) begin
               tr_d    = 1'b0;
               state_d = S_VERIFY_REL;
               // COM7 bit 7 is a self-clearing soft reset, so its readback never matches
               if (sub_q != COM7 && bus.sccb_r_data != wdat_q) err_d = 1'b1;
            end
         end
         S_VERIFY_REL: begin
            if (!bus.sccb_tr_end) begin
               rd_d = 1'b0;
               adv  = 1'b1;
            end
         end
`endif
         S_DELAY: begin
            if (cnt_q == '0) adv = 1'b1;
            else             cnt_d = cnt_q - 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      if (adv) begin
         if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_FETCH;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         sub_q   <= '0;
         wdat_q  <= '0;
         tr_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         first_q <= 1'b1;
`ifdef OV_SCCB_SEQ_VERIFY_EN
         rd_q    <= 1'b0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         sub_q   <= sub_d;
         wdat_q  <= wdat_d;
         tr_q    <= tr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         first_q <= first_d;
`ifdef OV_SCCB_SEQ_VERIFY_EN
         rd_q    <= rd_d;
         err_q   <= err_d;
`endif
      end
   end

   assign bus.rom_addr      = idx_q;
   assign bus.sccb_subaddr  = sub_q;
   assign bus.sccb_w_data   = wdat_q;
   assign bus.sccb_tr_start = tr_q;
   assign busy              = busy_q;
   assign done              = done_q;
`ifdef OV_SCCB_SEQ_VERIFY_EN
   assign bus.sccb_rd       = rd_q;
   assign error             = err_q;
`else
   assign error             = 1'b0;
`endif
endmodule
